// File: rtl/bitstream_packer.sv
// MSB-first bit packer: concatenates (value, length) codewords into 64-bit words and
// flushes to a byte boundary on request. Define BITPACK_STATS_EN to build the total_bits counter.
module bitstream_packer #(
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 input_enable,
    input  logic [OUT_WIDTH-1:0] val,
    input  logic [OUT_WIDTH-1:0] size_of_bit,
    input  logic                 flush_bit,
    output logic                 input_ready,
    output logic                 output_enable,
    output logic [OUT_WIDTH-1:0] output_data,
    output logic [3:0]           output_bytes,
    output logic                 output_last,
    output logic                 flush_done,
    output logic [31:0]          total_bits
);

    localparam int ACC_W = 2 * OUT_WIDTH;

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [6:0]           fill_q, fill_d;
    logic                 out_en_q, out_en_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [3:0]           out_bytes_q, out_bytes_d;
    logic                 out_last_q, out_last_d;
    logic                 flush_done_q, flush_done_d;

    logic                 accept;
    logic [6:0]           n_bits;
    logic [OUT_WIDTH-1:0] val_mask;
    logic [7:0]           shamt;
    logic [ACC_W-1:0]     acc_new;
    logic [6:0]           new_fill;

    // Only size_of_bit[6:0] carries the length; the rest is intentionally ignored.
    logic unused_size_bits;
    assign unused_size_bits = &{1'b0, size_of_bit[OUT_WIDTH-1:7]};

    function automatic logic [3:0] ceil_bytes(input logic [6:0] bits);
        return 4'((bits + 7'd7) >> 3);
    endfunction

    assign accept   = input_enable && (state_q == RUN);
    assign n_bits   = size_of_bit[6] ? 7'd64 : {1'b0, size_of_bit[5:0]};
    assign val_mask = n_bits[6] ? '1 : ((64'd1 << n_bits[5:0]) - 64'd1);
    // Left-justify the codeword so its MSB lands at bit 127-fill; a zero-length word shifts out entirely.
    assign shamt    = 8'd128 - {1'b0, fill_q} - {1'b0, n_bits};
    assign acc_new  = acc_q | ({{OUT_WIDTH{1'b0}}, val & val_mask} << shamt);
    assign new_fill = fill_q + n_bits;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        out_en_d     = 1'b0;
        out_data_d   = out_data_q;
        out_bytes_d  = 4'd0;
        out_last_d   = 1'b0;
        flush_done_d = 1'b0;

        case (state_q)
            RUN: begin
                if (accept) begin
                    if (flush_bit && new_fill == 7'd0) begin
                        flush_done_d = 1'b1;
                    end else if (flush_bit && new_fill <= 7'd64) begin
                        out_en_d     = 1'b1;
                        out_data_d   = acc_new[ACC_W-1:OUT_WIDTH];
                        out_bytes_d  = ceil_bytes(new_fill);
                        out_last_d   = 1'b1;
                        flush_done_d = 1'b1;
                        acc_d        = '0;
                        fill_d       = 7'd0;
                    end else if (new_fill >= 7'd64) begin
                        // Full word; a flush with leftover bits finishes them in DRAIN.
                        out_en_d    = 1'b1;
                        out_data_d  = acc_new[ACC_W-1:OUT_WIDTH];
                        out_bytes_d = 4'd8;
                        acc_d       = acc_new << OUT_WIDTH;
                        fill_d      = new_fill - 7'd64;
                        if (flush_bit) state_d = DRAIN;
                    end else begin
                        acc_d  = acc_new;
                        fill_d = new_fill;
                    end
                end
            end
            DRAIN: begin
                out_en_d     = 1'b1;
                out_data_d   = acc_q[ACC_W-1:OUT_WIDTH];
                out_bytes_d  = ceil_bytes(fill_q);
                out_last_d   = 1'b1;
                flush_done_d = 1'b1;
                acc_d        = '0;
                fill_d       = 7'd0;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            acc_q        <= '0;
            fill_q       <= 7'd0;
            out_en_q     <= 1'b0;
            out_data_q   <= '0;
            out_bytes_q  <= 4'd0;
            out_last_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            out_en_q     <= out_en_d;
            out_data_q   <= out_data_d;
            out_bytes_q  <= out_bytes_d;
            out_last_q   <= out_last_d;
            flush_done_q <= flush_done_d;
        end
    end

`ifdef BITPACK_STATS_EN
    logic [31:0] total_q, total_d;

    always_comb begin
        total_d = total_q;
        if (accept) total_d = total_q + {25'd0, n_bits};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) total_q <= 32'd0;
        else          total_q <= total_d;
    end

    assign total_bits = total_q;
`else
    assign total_bits = 32'd0;
`endif

    assign input_ready   = (state_q == RUN);
    assign output_enable = out_en_q;
    assign output_data   = out_data_q;
    assign output_bytes  = out_bytes_q;
    assign output_last   = out_last_q;
    assign flush_done    = flush_done_q;

endmodule

// File: tb/tb_bitstream_packer.sv
// Directed bench for bitstream_packer: hand-computed words, byte counts, flush
// sequencing, DRAIN input drop and asynchronous reset.
module tb_bitstream_packer;

`ifdef BITPACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        input_enable = 1'b0;
    logic [63:0] val = '0;
    logic [63:0] size_of_bit = '0;
    logic        flush_bit = 1'b0;
    logic        input_ready;
    logic        output_enable;
    logic [63:0] output_data;
    logic [3:0]  output_bytes;
    logic        output_last;
    logic        flush_done;
    logic [31:0] total_bits;

    int checks = 0;
    int errors = 0;

    bitstream_packer #(.OUT_WIDTH(64)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .input_enable  (input_enable),
        .val           (val),
        .size_of_bit   (size_of_bit),
        .flush_bit     (flush_bit),
        .input_ready   (input_ready),
        .output_enable (output_enable),
        .output_data   (output_data),
        .output_bytes  (output_bytes),
        .output_last   (output_last),
        .flush_done    (flush_done),
        .total_bits    (total_bits)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one codeword for one edge, then sample 1 time unit after it.
    task automatic send(input logic en, input logic [63:0] v, input logic [63:0] sz, input logic fl);
        input_enable = en;
        val          = v;
        size_of_bit  = sz;
        flush_bit    = fl;
        @(posedge clock);
        #1;
        input_enable = 1'b0;
        flush_bit    = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [63:0] data, input logic [3:0] bytes,
                              input logic last, input logic done);
        check({tag, "_en"},    {63'd0, output_enable}, 64'd1);
        check({tag, "_data"},  output_data, data);
        check({tag, "_bytes"}, {60'd0, output_bytes}, {60'd0, bytes});
        check({tag, "_last"},  {63'd0, output_last}, {63'd0, last});
        check({tag, "_done"},  {63'd0, flush_done}, {63'd0, done});
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_ready", {63'd0, input_ready}, 64'd1);
        check("rst_en",    {63'd0, output_enable}, 64'd0);
        check("rst_data",  output_data, 64'd0);
        check("rst_bytes", {60'd0, output_bytes}, 64'd0);
        check("rst_last",  {63'd0, output_last}, 64'd0);
        check("rst_done",  {63'd0, flush_done}, 64'd0);
        check("rst_total", {32'd0, total_bits}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Sixteen 4-bit 0xF codewords fill exactly one word
        for (int i = 0; i < 15; i++) send(1'b1, 64'hF, 64'd4, 1'b0);
        check("nibble15_en", {63'd0, output_enable}, 64'd0);
        send(1'b1, 64'hF, 64'd4, 1'b0);
        check_word("nibble16", 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 1'b0, 1'b0);
        send(1'b0, 64'h0, 64'd0, 1'b0);
        check("idle_en", {63'd0, output_enable}, 64'd0);

        // Four full-width words on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 64'h0123_4567_89AB_CDEF, 64'd64, 1'b0);
            check_word("full64", 64'h0123_4567_89AB_CDEF, 4'd8, 1'b0, 1'b0);
        end
        check("total_320", {32'd0, total_bits}, STATS ? 64'd320 : 64'd0);

        // Short flush: 3 bits -> one byte
        send(1'b1, 64'b101, 64'd3, 1'b1);
        check_word("flush3", 64'hA000_0000_0000_0000, 4'd1, 1'b1, 1'b1);
        check("flush3_ready", {63'd0, input_ready}, 64'd1);

        // Flush crossing a word boundary (F=70) -> DRAIN
        send(1'b1, 64'h0, 64'd60, 1'b0);
        check("fill60_en", {63'd0, output_enable}, 64'd0);
        send(1'b1, 64'h3FF, 64'd10, 1'b1);
        check_word("f70_first", 64'h0000_0000_0000_000F, 4'd8, 1'b0, 1'b0);
        check("f70_ready", {63'd0, input_ready}, 64'd0);
        send(1'b1, 64'hFF, 64'd8, 1'b0);
        check_word("f70_drain", 64'hFC00_0000_0000_0000, 4'd1, 1'b1, 1'b1);
        check("f70_ready_back", {63'd0, input_ready}, 64'd1);

        // Zero-length flush at fill 0 also proves the DRAIN-time codeword was dropped
        send(1'b1, 64'hFFFF, 64'd0, 1'b1);
        check("f0_en",    {63'd0, output_enable}, 64'd0);
        check("f0_done",  {63'd0, flush_done}, 64'd1);
        check("f0_bytes", {60'd0, output_bytes}, 64'd0);
        check("f0_last",  {63'd0, output_last}, 64'd0);

        // Oversized length saturates to 64; masking of bits above the length
        send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 1'b0);
        check_word("sat100", 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 1'b0, 1'b0);
        send(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 1'b1);
        check_word("mask4", 64'hF000_0000_0000_0000, 4'd1, 1'b1, 1'b1);
        send(1'b1, 64'h1FF, 64'd9, 1'b1);
        check_word("flush9", 64'hFF80_0000_0000_0000, 4'd2, 1'b1, 1'b1);
        send(1'b1, 64'h0123_4567_89AB_CDEF, 64'd64, 1'b1);
        check_word("flush64", 64'h0123_4567_89AB_CDEF, 4'd8, 1'b1, 1'b1);
        check("flush64_ready", {63'd0, input_ready}, 64'd1);
        check("total_534", {32'd0, total_bits}, STATS ? 64'd534 : 64'd0);

        // Reset while in DRAIN
        send(1'b1, 64'h0, 64'd60, 1'b0);
        send(1'b1, 64'h3FF, 64'd10, 1'b1);
        check("pre_rst_ready", {63'd0, input_ready}, 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ready", {63'd0, input_ready}, 64'd1);
        check("arst_en",    {63'd0, output_enable}, 64'd0);
        check("arst_data",  output_data, 64'd0);
        check("arst_bytes", {60'd0, output_bytes}, 64'd0);
        check("arst_last",  {63'd0, output_last}, 64'd0);
        check("arst_done",  {63'd0, flush_done}, 64'd0);
        check("arst_total", {32'd0, total_bits}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        send(1'b1, 64'h7F, 64'd7, 1'b0);
        check("post_rst_en",    {63'd0, output_enable}, 64'd0);
        check("post_rst_total", {32'd0, total_bits}, STATS ? 64'd7 : 64'd0);
        send(1'b1, 64'h0, 64'd0, 1'b1);
        check_word("post_rst_flush", 64'hFE00_0000_0000_0000, 4'd1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitstream_packer.md
# bitstream_packer

Downstream neighbour of the AC VLC stage in the ProRes encoder. It accepts variable-length codewords as (value, bit count) pairs and concatenates them MSB-first into a continuous bitstream, emitting 64-bit words. A flush request zero-pads the stream to a byte boundary and emits the final partial word. The slice/frame writer consumes its output.

## Interface
- `OUT_WIDTH`, default 64: output word width in bits. Only 64 is supported; the accumulator is sized 2×OUT_WIDTH.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `input_enable`  in  1  codeword valid this cycle; ignored while `input_ready`=0.
- `val`  in  64  codeword in its LSBs; bits at and above `size_of_bit` are ignored (masked).
- `size_of_bit`  in  64  codeword length; only [6:0] is used; 0 is legal (no bits); 65..127 saturate to 64.
- `flush_bit`  in  1  qualified by `input_enable`: append this codeword, then pad and drain.
- `input_ready`  out  1  packer can accept a codeword this cycle.
- `output_enable`  out  1  `output_data` valid.
- `output_data`  out  64  packed word, first stream bit at bit 63.
- `output_bytes`  out  4  valid bytes in `output_data`, 1..8 (8 for every full word).
- `output_last`  out  1  final word of a flush sequence.
- `flush_done`  out  1  one-cycle pulse when the flush sequence completes.
- `total_bits`  out  32  cumulative accepted bit count (see Configuration).

## Operation
- Accumulator `acc[127:0]` and fill counter `fill[6:0]` (0..63 between cycles). The next free bit is at position 127-fill.
- Accept (`input_enable` && `input_ready`): n = min(size_of_bit[6:0], 64). Insert masked val[n-1:0] MSB-first at position 127-fill, giving new fill = fill+n (max 127).
- When new fill ≥ 64: register acc[127:64] as the output word with `output_bytes`=8, shift acc left by 64, and subtract 64 from fill. At most one word is produced per cycle, so no backpressure occurs in RUN.
- States:
  - RUN: `input_ready`=1.
  - DRAIN: `input_ready`=0; entered only on a flush whose new fill > 64.
- Flush accepted in RUN, by new fill F (the codeword is included first):
  - F=0: no word is output; `flush_done` pulses.
  - 1≤F≤64: one word with bits beyond F zeroed, `output_bytes`=ceil(F/8), `output_last`=1, `flush_done`=1; fill←0; stay in RUN.
  - F>64: full word now (`output_last`=0); go to DRAIN.
- DRAIN, next cycle: emit the remaining F-64 bits as above with `output_last`=1 and `flush_done`=1; fill←0; return to RUN.
- `input_enable` during DRAIN is dropped. It does not count toward `total_bits`.
- Padding bits are always 0.
- Reset, including mid-flush: state→RUN, acc←0, fill←0, `total_bits`←0, and all outputs take their reset values.

## Timing
- Reset values:
  - `input_ready`=1
  - `output_enable`=0, `output_data`=0, `output_bytes`=0
  - `output_last`=0, `flush_done`=0
  - `total_bits`=0
- All outputs are registered. A word completed by the codeword accepted at edge N is visible after edge N (one-cycle latency). `output_enable` is high for exactly one cycle per word.
- `input_ready` drops in the cycle after a flush with F>64 is accepted. It returns high one cycle later; the flush-to-next-accept gap is one cycle.
- `output_bytes`, `output_last` and `flush_done` are 0 whenever `output_enable`=0, except `flush_done` in the F=0 case.

## Configuration
- `BITPACK_STATS_EN` defined: `total_bits` increments by n on every accepted codeword and wraps modulo 2^32. Padding bits are not counted.
- `BITPACK_STATS_EN` undefined: `total_bits` is tied to 0 and no counter logic is built.

## Test plan
- Sixteen codewords, each val=0xF with size 4 → one word 0xFFFF_FFFF_FFFF_FFFF with bytes=8, one cycle after the 16th accept.
- Size 64, val=0x0123_4567_89AB_CDEF, every cycle for 4 cycles → four identical words on consecutive cycles; fill stays 0.
- Size 3, val=0b101, flush=1 → word 0xA000_0000_0000_0000 with bytes=1, last=1, flush_done=1.
- Size 60 (val=0), then size 10 val=0x3FF with flush → word 0x0000_0000_0000_000F (bytes 8, last 0), `input_ready`=0 one cycle, then 0xFC00_0000_0000_0000 (bytes 1, last 1).
- Size 0 with flush at fill 0 → no `output_enable`, `flush_done` pulses; size_of_bit=100, val=all-ones → treated as 64 bits.
- Reset_n low mid-DRAIN → outputs 0, `input_ready`=1 asynchronously. With `BITPACK_STATS_EN`, `total_bits` returns 0 and counts 7 after a subsequent size-7 accept.
